// File: rtl/conv_seq_ctrl.sv
// Single-FSM sequencer for the P-lane convolution datapath: loads a frame of x samples,
// runs the MAC passes, writes each pass to output memory and streams the results out.
module conv_seq_ctrl #(
    parameter int LENX  = 8,
    parameter int LENF  = 4,
    parameter int P     = 3,
    parameter int ADDRX = 3,
    parameter int ADDRF = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid_x,
    output logic               s_ready_x,
    output logic               x_wr_en,
    output logic [ADDRX-1:0]   x_wr_addr,
    output logic [P*ADDRX-1:0] x_rd_addr,
    output logic [ADDRF-1:0]   f_rd_addr,
    output logic               clr_acc,
    output logic               en_acc,
    output logic               y_wr_en,
    output logic [ADDRX-1:0]   y_wr_base,
    output logic [P-1:0]       y_wr_mask,
    output logic [ADDRX-1:0]   y_rd_addr,
    output logic               m_valid_y,
    input  logic               m_ready_y,
    output logic               frame_done
);

    localparam int SIZE  = LENX - LENF + 1;
    localparam int NPASS = (SIZE + P - 1) / P;
    localparam int PASSW = (NPASS > 1) ? $clog2(NPASS) : 1;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_MAC,
        ST_TAIL,
        ST_WRITE,
        ST_RD,
        ST_SEND
    } state_t;

    state_t             state_q, state_d;
    logic [ADDRX-1:0]   xcnt_q, xcnt_d;
    logic [ADDRF-1:0]   tap_q, tap_d;
    logic [PASSW-1:0]   pass_q, pass_d;
    logic [ADDRX-1:0]   ycnt_q, ycnt_d;
    logic               frame_done_q, frame_done_d;

    // Lanes past the end of the sample buffer read the last sample; their results are masked off.
    function automatic logic [ADDRX-1:0] lane_addr(input logic [PASSW-1:0] pass,
                                                   input logic [ADDRF-1:0] tap,
                                                   input int lane);
        int a;
        a = int'(pass) * P + lane + int'(tap);
        if (a > LENX - 1) a = LENX - 1;
        return ADDRX'(a);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            xcnt_q       <= '0;
            tap_q        <= '0;
            pass_q       <= '0;
            ycnt_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            xcnt_q       <= xcnt_d;
            tap_q        <= tap_d;
            pass_q       <= pass_d;
            ycnt_q       <= ycnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        xcnt_d       = xcnt_q;
        tap_d        = tap_q;
        pass_d       = pass_q;
        ycnt_d       = ycnt_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (s_valid_x) begin
                    if (int'(xcnt_q) == LENX - 1) begin
                        state_d = ST_MAC;
                        pass_d  = '0;
                        tap_d   = '0;
                    end else begin
                        xcnt_d = xcnt_q + 1'b1;
                    end
                end
            end
            ST_MAC: begin
                if (int'(tap_q) == LENF - 1) state_d = ST_TAIL;
                else                         tap_d   = tap_q + 1'b1;
            end
            ST_TAIL: state_d = ST_WRITE;
            ST_WRITE: begin
                if (int'(pass_q) == NPASS - 1) begin
                    state_d = ST_RD;
                    ycnt_d  = '0;
                end else begin
                    state_d = ST_MAC;
                    pass_d  = pass_q + 1'b1;
                    tap_d   = '0;
                end
            end
            ST_RD: state_d = ST_SEND;
            ST_SEND: begin
                if (m_ready_y) begin
                    if (int'(ycnt_q) == SIZE - 1) begin
                        // Registered so the pulse carries no path from m_ready_y.
                        frame_done_d = 1'b1;
                        xcnt_d       = '0;
                        state_d      = ST_LOAD;
                    end else begin
                        ycnt_d  = ycnt_q + 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        s_ready_x = 1'b0;
        x_wr_addr = '0;
        x_rd_addr = '0;
        f_rd_addr = '0;
        clr_acc   = 1'b0;
        en_acc    = 1'b0;
        y_wr_en   = 1'b0;
        y_wr_base = '0;
        y_wr_mask = '0;
        y_rd_addr = '0;
        m_valid_y = 1'b0;
        case (state_q)
            ST_LOAD: begin
                s_ready_x = ~reset;
                x_wr_addr = xcnt_q;
            end
            ST_MAC, ST_TAIL: begin
                f_rd_addr = tap_q;
                for (int i = 0; i < P; i++) begin
                    x_rd_addr[i*ADDRX +: ADDRX] = lane_addr(pass_q, tap_q, i);
                end
                // Memory read latency: the product of tap t is accumulated one cycle later.
                clr_acc = (state_q == ST_MAC) && (tap_q == '0);
                en_acc  = (state_q == ST_TAIL) || (tap_q != '0);
            end
            ST_WRITE: begin
                y_wr_en   = 1'b1;
                y_wr_base = ADDRX'(int'(pass_q) * P);
                for (int i = 0; i < P; i++) begin
                    y_wr_mask[i] = (int'(pass_q) * P + i) < SIZE;
                end
            end
            ST_RD, ST_SEND: begin
                y_rd_addr = ycnt_q;
                m_valid_y = (state_q == ST_SEND);
            end
            default: ;
        endcase
    end

    assign x_wr_en    = s_valid_x & s_ready_x;
    assign frame_done = frame_done_q;

    a_xcnt: assert property (@(posedge clk) disable iff (reset) int'(xcnt_q) < LENX);
    a_tap:  assert property (@(posedge clk) disable iff (reset) int'(tap_q) < LENF);
    a_pass: assert property (@(posedge clk) disable iff (reset) int'(pass_q) < NPASS);
    a_ycnt: assert property (@(posedge clk) disable iff (reset) int'(ycnt_q) < SIZE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: memory/MAC model around the sequencer, cycle table for one frame,
// scoreboard of golden convolution results, stall and mid-frame reset sequences.
module tb_conv_seq_ctrl;

    localparam int LENX  = 8;
    localparam int LENF  = 4;
    localparam int P     = 3;
    localparam int ADDRX = 3;
    localparam int ADDRF = 2;
    localparam int SIZE  = LENX - LENF + 1;

    logic               clk;
    logic               reset;
    logic               s_valid_x;
    logic               s_ready_x;
    logic               x_wr_en;
    logic [ADDRX-1:0]   x_wr_addr;
    logic [P*ADDRX-1:0] x_rd_addr;
    logic [ADDRF-1:0]   f_rd_addr;
    logic               clr_acc;
    logic               en_acc;
    logic               y_wr_en;
    logic [ADDRX-1:0]   y_wr_base;
    logic [P-1:0]       y_wr_mask;
    logic [ADDRX-1:0]   y_rd_addr;
    logic               m_valid_y;
    logic               m_ready_y;
    logic               frame_done;

    conv_seq_ctrl #(.LENX(LENX), .LENF(LENF), .P(P), .ADDRX(ADDRX), .ADDRF(ADDRF)) dut (
        .clk(clk), .reset(reset),
        .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
        .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_rd_addr(x_rd_addr),
        .f_rd_addr(f_rd_addr), .clr_acc(clr_acc), .en_acc(en_acc),
        .y_wr_en(y_wr_en), .y_wr_base(y_wr_base), .y_wr_mask(y_wr_mask),
        .y_rd_addr(y_rd_addr), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: synchronous-read memories, filter ROM, P accumulators.
    int                 F [LENF] = '{-12, -14, 3, -6};
    logic signed [7:0]  x_in;
    logic signed [7:0]  x_mem [LENX];
    logic signed [7:0]  xr [P];
    logic signed [7:0]  fr;
    logic signed [31:0] acc [P];
    logic signed [31:0] y_mem [LENX];
    logic signed [31:0] m_data_out_y;

    always @(posedge clk) begin
        if (x_wr_en) x_mem[x_wr_addr] <= x_in;
        for (int i = 0; i < P; i++) begin
            xr[i] <= x_mem[x_rd_addr[i*ADDRX +: ADDRX]];
            if (clr_acc)     acc[i] <= 0;
            else if (en_acc) acc[i] <= acc[i] + xr[i] * fr;
            if (y_wr_en && y_wr_mask[i]) y_mem[int'(y_wr_base) + i] <= acc[i];
        end
        fr           <= 8'(F[f_rd_addr]);
        m_data_out_y <= y_mem[y_rd_addr];
    end

    typedef struct {
        logic sv, mr;
        logic rdy, wen;
        logic [2:0] wa;
        logic [8:0] xra;
        logic [1:0] fa;
        logic clr, en, ywe;
        logic [2:0] base, mask, yra;
        logic mv, fd;
    } vec_t;

    vec_t tab [$];
    int   sb [$];
    int   xs_cur [LENX];
    int   sidx, nhs, nfd;
    int   nchk, nerr;
    logic sv_req, mr_req;

    function automatic vec_t z(input logic sv, input logic mr);
        vec_t v;
        v = '{default: 0};
        v.sv = sv;
        v.mr = mr;
        return v;
    endfunction

    function automatic vec_t mac(input int a0, input int a1, input int a2, input int fa,
                                 input logic clr, input logic en);
        vec_t v;
        v     = z(1'b1, 1'b1);
        v.xra = {3'(a2), 3'(a1), 3'(a0)};
        v.fa  = 2'(fa);
        v.clr = clr;
        v.en  = en;
        return v;
    endfunction

    function automatic logic [31:0] pk(input vec_t v);
        return 32'({v.rdy, v.wen, v.wa, v.xra, v.fa, v.clr, v.en, v.ywe,
                    v.base, v.mask, v.yra, v.mv, v.fd});
    endfunction

    function automatic logic [31:0] act();
        return 32'({s_ready_x, x_wr_en, x_wr_addr, x_rd_addr, f_rd_addr, clr_acc, en_acc,
                    y_wr_en, y_wr_base, y_wr_mask, y_rd_addr, m_valid_y, frame_done});
    endfunction

    function automatic int gold(input int k);
        int s = 0;
        for (int t = 0; t < LENF; t++) s += xs_cur[k + t] * F[t];
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic new_frame(input bit rnd);
        for (int j = 0; j < LENX; j++)
            xs_cur[j] = rnd ? int'($urandom_range(0, 255)) - 128 : j + 1;
        sidx = 0;
        nhs  = 0;
        nfd  = 0;
    endtask

    task automatic observe();
        if (s_valid_x && s_ready_x && sidx < LENX) begin
            sidx++;
            if (sidx == LENX)
                for (int k = 0; k < SIZE; k++) sb.push_back(gold(k));
        end
        if (m_valid_y && m_ready_y) begin
            nhs++;
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL y_unexpected: got %h expected no output", m_data_out_y);
            end else begin
                chk($sformatf("y[%0d]", nhs - 1), m_data_out_y, sb.pop_front());
            end
        end
        if (frame_done) nfd++;
    endtask

    task automatic drive();
        s_valid_x = sv_req && (sidx < LENX);
        x_in      = (sidx < LENX) ? 8'(xs_cur[sidx]) : 8'sd0;
        m_ready_y = mr_req;
    endtask

    task automatic step();
        #1;
        observe();
        @(negedge clk);
    endtask

    task automatic run_until_done(input string nm, input int budget);
        int n = 0;
        while (nfd == 0 && n < budget) begin
            drive();
            step();
            n++;
        end
        if (nfd == 0) begin
            nchk++;
            nerr++;
            $display("FAIL %s_timeout: got no frame_done expected one within %0d cycles", nm, budget);
        end
    endtask

    task automatic end_frame(input string nm);
        chk({nm, "_handshakes"}, 32'(nhs), 32'(SIZE));
        chk({nm, "_frame_done"}, 32'(nfd), 32'd1);
        sv_req = 1'b0;
        drive();
        #1;
        chk({nm, "_after_done"}, 32'({s_ready_x, frame_done}), 32'b10);
        observe();
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        int   n;
        nchk = 0;
        nerr = 0;
        reset = 1'b1;
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        x_in = '0;
        sv_req = 1'b0;
        mr_req = 1'b0;

        // Full-rate frame, cycle by cycle from reset release.
        for (int j = 0; j < LENX; j++) begin
            v = z(1'b1, 1'b1); v.rdy = 1'b1; v.wen = 1'b1; v.wa = 3'(j); tab.push_back(v);
        end
        tab.push_back(mac(0, 1, 2, 0, 1'b1, 1'b0));
        tab.push_back(mac(1, 2, 3, 1, 1'b0, 1'b1));
        tab.push_back(mac(2, 3, 4, 2, 1'b0, 1'b1));
        tab.push_back(mac(3, 4, 5, 3, 1'b0, 1'b1));
        tab.push_back(mac(3, 4, 5, 3, 1'b0, 1'b1));
        v = z(1'b1, 1'b1); v.ywe = 1'b1; v.base = 3'd0; v.mask = 3'b111; tab.push_back(v);
        tab.push_back(mac(3, 4, 5, 0, 1'b1, 1'b0));
        tab.push_back(mac(4, 5, 6, 1, 1'b0, 1'b1));
        tab.push_back(mac(5, 6, 7, 2, 1'b0, 1'b1));
        tab.push_back(mac(6, 7, 7, 3, 1'b0, 1'b1));
        tab.push_back(mac(6, 7, 7, 3, 1'b0, 1'b1));
        v = z(1'b1, 1'b1); v.ywe = 1'b1; v.base = 3'd3; v.mask = 3'b011; tab.push_back(v);
        for (int k = 0; k < SIZE; k++) begin
            v = z(1'b1, 1'b1); v.yra = 3'(k); tab.push_back(v);
            v.mv = 1'b1; tab.push_back(v);
        end
        v = z(1'b0, 1'b1); v.rdy = 1'b1; v.fd = 1'b1; tab.push_back(v);

        // Reset state, with s_valid_x high to show no write leaks through.
        @(negedge clk);
        s_valid_x = 1'b1;
        #1;
        chk("reset_outputs", act(), 32'd0);
        @(negedge clk);

        // Frame A: table vectors, x = 1..8.
        new_frame(1'b0);
        reset = 1'b0;
        for (int r = 0; r < tab.size(); r++) begin
            s_valid_x = tab[r].sv;
            m_ready_y = tab[r].mr;
            x_in = (sidx < LENX) ? 8'(xs_cur[sidx]) : 8'sd0;
            #1;
            chk($sformatf("row%0d", r), act(), pk(tab[r]));
            observe();
            @(negedge clk);
        end
        end_frame("frameA");

        // Frame B: random samples, downstream stalls 10 cycles on the first output.
        new_frame(1'b1);
        sv_req = 1'b1;
        mr_req = 1'b0;
        n = 0;
        while (!m_valid_y && n < 40) begin
            drive();
            step();
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            drive();
            #1;
            chk($sformatf("stall%0d", c), 32'({m_valid_y, y_rd_addr}), 32'({1'b1, 3'd0}));
            observe();
            @(negedge clk);
        end
        mr_req = 1'b1;
        run_until_done("frameB", 60);
        end_frame("frameB");

        // Frame C: reset during pass 0 MAC, then a clean frame.
        new_frame(1'b0);
        sv_req = 1'b1;
        mr_req = 1'b1;
        n = 0;
        while (!clr_acc && n < 40) begin
            drive();
            step();
            n++;
        end
        drive();
        step();
        reset = 1'b1;
        #1;
        chk("reset_async", act(), 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        new_frame(1'b0);
        reset = 1'b0;
        drive();
        #1;
        v = z(1'b1, 1'b1); v.rdy = 1'b1; v.wen = 1'b1; v.wa = 3'd0;
        chk("reset_release", act(), pk(v));
        observe();
        @(negedge clk);
        run_until_done("frameC", 60);
        end_frame("frameC");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
